// File: rtl/rect_pixel_collector.sv
// rect_pixel_collector: sink for generator coordinate streams; rasterises (row, col) beats
// into a bit-packed framebuffer, keeps pixel/overlap/clip stats, then streams rows out.
// Latency: beat lands in the framebuffer on the accept edge, visible to the next beat.
// Backpressure: i_in_valid/o_in_ready on input and o_row_valid/i_row_ready on readout;
// readout outputs hold while i_row_ready is low.
//
// Optional feature macro: RECT_PIXEL_COLLECTOR_BBOX_EN (bounding-box tracking).
// Undefined: o_bb_* ports are tied to 0 and no bounding-box registers exist.
//
// Ports:
//   i_clock, i_reset_n            clock, async active-low reset
//   i_start                       one-cycle pulse: clear framebuffer, start collecting
//   i_in0/i_in1, i_in_valid,
//   o_in_ready, i_in_done         coordinate stream (row, column) and end-of-stream
//   o_row_data/o_row_idx,
//   o_row_valid, i_row_ready      framebuffer readout, one row per handshake
//   o_pixel_count, o_overlap_count,
//   o_clip_count                  statistics (wrap modulo 2^WIDTH)
//   o_bb_min0/1, o_bb_max0/1      bounding box of in-bounds beats
//   o_done                        readout finished
module rect_pixel_collector #(
  parameter int WIDTH = 32,
  parameter int FB_W  = 16,
  parameter int FB_H  = 16
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_in_done,
  output logic [FB_W-1:0]  o_row_data,
  output logic [WIDTH-1:0] o_row_idx,
  output logic             o_row_valid,
  input  logic             i_row_ready,
  output logic [WIDTH-1:0] o_pixel_count,
  output logic [WIDTH-1:0] o_overlap_count,
  output logic [WIDTH-1:0] o_clip_count,
  output logic [WIDTH-1:0] o_bb_min0,
  output logic [WIDTH-1:0] o_bb_min1,
  output logic [WIDTH-1:0] o_bb_max0,
  output logic [WIDTH-1:0] o_bb_max1,
  output logic             o_done
);

  localparam int RW = (FB_H > 1) ? $clog2(FB_H) : 1;
  localparam int CW = (FB_W > 1) ? $clog2(FB_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLECT,
    S_READOUT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [RW-1:0]    r_clr_idx;
  logic [WIDTH-1:0] r_row_idx;
  logic [FB_W-1:0]  r_row_data;
  logic             r_row_valid;
  logic             r_in_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_pixel_count;
  logic [WIDTH-1:0] r_overlap_count;
  logic [WIDTH-1:0] r_clip_count;

  // Framebuffer is never reset; a CLEAR pass defines its contents.
  logic [FB_W-1:0]  r_fb [FB_H];

  logic             w_accept;
  logic             w_in_bounds;
  logic             w_set;
  logic             w_hit;
  logic [RW-1:0]    w_row;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_rd_row;
  logic [RW-1:0]    w_next_row;
  logic             w_last_row;

  // r_in_ready is only ever high in COLLECT, so it doubles as the state qualifier.
  assign w_accept    = r_in_ready & i_in_valid;
  assign w_in_bounds = (i_in0 < WIDTH'(FB_H)) && (i_in1 < WIDTH'(FB_W));
  assign w_set       = w_accept & w_in_bounds;
  assign w_row       = i_in0[RW-1:0];
  assign w_col       = i_in1[CW-1:0];
  // Reading the flop array directly gives read-after-write for back-to-back beats:
  // the previous beat's bit is already committed on this cycle.
  assign w_hit       = r_fb[w_row][w_col];
  assign w_rd_row    = r_row_idx[RW-1:0];
  assign w_next_row  = w_rd_row + RW'(1);
  assign w_last_row  = (r_row_idx == WIDTH'(FB_H - 1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= S_IDLE;
      r_clr_idx       <= '0;
      r_row_idx       <= '0;
      r_row_data      <= '0;
      r_row_valid     <= 1'b0;
      r_in_ready      <= 1'b0;
      r_done          <= 1'b0;
      r_pixel_count   <= '0;
      r_overlap_count <= '0;
      r_clip_count    <= '0;
    end else if (i_start) begin
      r_state         <= S_CLEAR;
      r_clr_idx       <= '0;
      r_row_idx       <= '0;
      r_row_data      <= '0;
      r_row_valid     <= 1'b0;
      r_in_ready      <= 1'b0;
      r_done          <= 1'b0;
      r_pixel_count   <= '0;
      r_overlap_count <= '0;
      r_clip_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_CLEAR: begin
          if (r_clr_idx == RW'(FB_H - 1)) begin
            r_state    <= S_COLLECT;
            r_in_ready <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + RW'(1);
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            if (w_in_bounds) begin
              r_pixel_count <= r_pixel_count + WIDTH'(1);
              if (w_hit) r_overlap_count <= r_overlap_count + WIDTH'(1);
            end else begin
              r_clip_count <= r_clip_count + WIDTH'(1);
            end
          end
          if (i_in_done) begin
            r_state     <= S_READOUT;
            r_in_ready  <= 1'b0;
            r_row_idx   <= '0;
            r_row_valid <= 1'b0;
          end
        end
        S_READOUT: begin
          // First READOUT cycle loads row 0 so a beat accepted alongside
          // i_in_done is already in the framebuffer.
          if (!r_row_valid) begin
            r_row_valid <= 1'b1;
            r_row_data  <= r_fb[w_rd_row];
          end else if (i_row_ready) begin
            if (w_last_row) begin
              r_state     <= S_DONE;
              r_row_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_row_idx  <= r_row_idx + WIDTH'(1);
              r_row_data <= r_fb[w_next_row];
            end
          end
        end
        S_DONE: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_start) begin
      if (r_state == S_CLEAR) begin
        r_fb[r_clr_idx] <= '0;
      end else if (w_set) begin
        r_fb[w_row][w_col] <= 1'b1;
      end
    end
  end

`ifdef RECT_PIXEL_COLLECTOR_BBOX_EN
  logic [WIDTH-1:0] r_bb_min0;
  logic [WIDTH-1:0] r_bb_min1;
  logic [WIDTH-1:0] r_bb_max0;
  logic [WIDTH-1:0] r_bb_max1;

  // min all ones / max zero encodes an empty box.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bb_min0 <= '1;
      r_bb_min1 <= '1;
      r_bb_max0 <= '0;
      r_bb_max1 <= '0;
    end else if (i_start) begin
      r_bb_min0 <= '1;
      r_bb_min1 <= '1;
      r_bb_max0 <= '0;
      r_bb_max1 <= '0;
    end else if (w_set) begin
      if (i_in0 < r_bb_min0) r_bb_min0 <= i_in0;
      if (i_in1 < r_bb_min1) r_bb_min1 <= i_in1;
      if (i_in0 > r_bb_max0) r_bb_max0 <= i_in0;
      if (i_in1 > r_bb_max1) r_bb_max1 <= i_in1;
    end
  end

  assign o_bb_min0 = r_bb_min0;
  assign o_bb_min1 = r_bb_min1;
  assign o_bb_max0 = r_bb_max0;
  assign o_bb_max1 = r_bb_max1;
`else
  assign o_bb_min0 = '0;
  assign o_bb_min1 = '0;
  assign o_bb_max0 = '0;
  assign o_bb_max1 = '0;
`endif

  assign o_in_ready      = r_in_ready;
  assign o_row_data      = r_row_data;
  assign o_row_idx       = r_row_idx;
  assign o_row_valid     = r_row_valid;
  assign o_pixel_count   = r_pixel_count;
  assign o_overlap_count = r_overlap_count;
  assign o_clip_count    = r_clip_count;
  assign o_done          = r_done;

endmodule

// File: tb/tb_rect_pixel_collector.sv
// tb_rect_pixel_collector: scoreboard bench for rect_pixel_collector.
// Beats update a small framebuffer model as they are driven; expected rows are queued
// at end-of-stream and popped as the DUT's readout handshakes complete.
module tb_rect_pixel_collector;

  localparam int WIDTH = 32;
  localparam int FB_W  = 16;
  localparam int FB_H  = 16;
`ifdef RECT_PIXEL_COLLECTOR_BBOX_EN
  localparam bit BB_EN = 1'b1;
`else
  localparam bit BB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] in0 = '0;
  logic [WIDTH-1:0] in1 = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_done = 1'b0;
  logic [FB_W-1:0]  row_data;
  logic [WIDTH-1:0] row_idx;
  logic             row_valid;
  logic             row_ready = 1'b0;
  logic [WIDTH-1:0] pixel_count, overlap_count, clip_count;
  logic [WIDTH-1:0] bb_min0, bb_min1, bb_max0, bb_max1;
  logic             done;

  always #5 clk = ~clk;

  rect_pixel_collector #(.WIDTH(WIDTH), .FB_W(FB_W), .FB_H(FB_H)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start),
    .i_in0(in0), .i_in1(in1), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_done(in_done),
    .o_row_data(row_data), .o_row_idx(row_idx), .o_row_valid(row_valid),
    .i_row_ready(row_ready),
    .o_pixel_count(pixel_count), .o_overlap_count(overlap_count),
    .o_clip_count(clip_count),
    .o_bb_min0(bb_min0), .o_bb_min1(bb_min1), .o_bb_max0(bb_max0), .o_bb_max1(bb_max1),
    .o_done(done)
  );

  int errors = 0;
  int checks = 0;

  // Model state
  logic [FB_W-1:0]  mfb [FB_H];
  int unsigned      m_pix, m_ovl, m_clp;
  logic [WIDTH-1:0] m_min0, m_min1, m_max0, m_max1;
  int               q_idx [$];
  logic [FB_W-1:0]  q_dat [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < FB_H; r++) mfb[r] = '0;
    m_pix = 0; m_ovl = 0; m_clp = 0;
    m_min0 = '1; m_min1 = '1; m_max0 = '0; m_max1 = '0;
    q_idx.delete(); q_dat.delete();
  endtask

  task automatic model_beat(input int r, input int c);
    if (r < FB_H && c < FB_W) begin
      if (mfb[r][c]) m_ovl++;
      mfb[r][c] = 1'b1;
      m_pix++;
      if (WIDTH'(r) < m_min0) m_min0 = WIDTH'(r);
      if (WIDTH'(c) < m_min1) m_min1 = WIDTH'(c);
      if (WIDTH'(r) > m_max0) m_max0 = WIDTH'(r);
      if (WIDTH'(c) > m_max1) m_max1 = WIDTH'(c);
    end else begin
      m_clp++;
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_pix"}, pixel_count, m_pix);
    check({tag, "_ovl"}, overlap_count, m_ovl);
    check({tag, "_clip"}, clip_count, m_clp);
    check({tag, "_bbmin0"}, bb_min0, BB_EN ? m_min0 : '0);
    check({tag, "_bbmin1"}, bb_min1, BB_EN ? m_min1 : '0);
    check({tag, "_bbmax0"}, bb_max0, BB_EN ? m_max0 : '0);
    check({tag, "_bbmax1"}, bb_max1, BB_EN ? m_max1 : '0);
  endtask

  // Pulse start, then measure the CLEAR length until in_ready rises.
  task automatic start_frame();
    int cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    check("start_done", done, 0);
    check("start_pix", pixel_count, 0);
    check("start_ready", in_ready, 0);
    check("start_rvalid", row_valid, 0);
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("clear_len", cnt, FB_H);
  endtask

  task automatic send_beat(input int r, input int c);
    in_valid = 1'b1;
    in0 = WIDTH'(r);
    in1 = WIDTH'(c);
    model_beat(r, c);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // End the stream, optionally with a final beat in the same cycle.
  task automatic finish_collect(input bit with_beat, input int r, input int c);
    in_done = 1'b1;
    in_valid = with_beat;
    in0 = WIDTH'(r);
    in1 = WIDTH'(c);
    if (with_beat) model_beat(r, c);
    @(negedge clk);
    in_done = 1'b0;
    in_valid = 1'b0;
    check("ready_drop", in_ready, 0);
    for (int i = 0; i < FB_H; i++) begin
      q_idx.push_back(i);
      q_dat.push_back(mfb[i]);
    end
  endtask

  // Drain readout; stall at stall_at for stall_n cycles; return early at abort_at.
  task automatic drain(input int stall_at, input int stall_n, input int abort_at);
    int stalled = 0;
    int hs = 0;
    int cyc = 0;
    row_ready = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (row_valid) begin
        if (q_idx.size() == 0) begin
          check("rd_extra", 1, 0);
          row_ready = 1'b0;
          break;
        end
        check("rd_idx", row_idx, q_idx[0]);
        check("rd_dat", row_data, q_dat[0]);
        if (int'(row_idx) == abort_at) begin
          row_ready = 1'b0;
          return;
        end
        if (int'(row_idx) == stall_at && stalled < stall_n) begin
          row_ready = 1'b0;
          stalled++;
        end else begin
          row_ready = 1'b1;
          void'(q_idx.pop_front());
          void'(q_dat.pop_front());
          hs++;
        end
      end else begin
        row_ready = 1'b0;
      end
    end
    row_ready = 1'b0;
    check("rd_done", done, 1);
    check("rd_handshakes", hs, FB_H);
    check("rd_left", q_idx.size(), 0);
    check("rd_stalls", stalled, stall_n);
  endtask

  initial begin
    model_clear();
    #12;
    // Reset values
    check("rst_ready", in_ready, 0);
    check("rst_rvalid", row_valid, 0);
    check("rst_done", done, 0);
    check("rst_rdat", row_data, 0);
    check("rst_ridx", row_idx, 0);
    check_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;
    // Beats in IDLE are ignored
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_ready", in_ready, 0);
    check("idle_pix", pixel_count, 0);

    // Rectangle s_x=2, s_y=3, height=4, width=5
    start_frame();
    for (int c = 3; c <= 7; c++) begin
      send_beat(2, c);
      send_beat(5, c);
    end
    for (int r = 2; r <= 5; r++) begin
      send_beat(r, 3);
      send_beat(r, 7);
    end
    finish_collect(1'b0, 0, 0);
    check("rect_pix_lit", pixel_count, 18);
    check("rect_ovl_lit", overlap_count, 4);
    check("rect_row2_lit", mfb[2], 16'h00F8);
    check("rect_row3_lit", mfb[3], 16'h0088);
    check_stats("rect");
    drain(4, 3, -1);
    check_stats("rect_done");

    // Out-of-bounds beats only
    start_frame();
    send_beat(20, 1);
    send_beat(1, 16);
    finish_collect(1'b0, 0, 0);
    check_stats("clip");
    drain(-1, 0, -1);

    // Back-to-back overlap, then a beat together with in_done; abort readout at row 7
    start_frame();
    send_beat(1, 1);
    send_beat(1, 1);
    finish_collect(1'b1, 0, 0);
    check("b2b_row0", mfb[0], 16'h0001);
    check_stats("b2b");
    drain(-1, 0, 7);
    start_frame();
    check("abort_ovl", overlap_count, 0);
    check("abort_clip", clip_count, 0);
    send_beat(9, 9);
    send_beat(15, 0);
    finish_collect(1'b0, 0, 0);
    check_stats("fresh");
    drain(-1, 0, -1);

    // Async reset mid-collect
    start_frame();
    send_beat(3, 3);
    send_beat(20, 20);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", in_ready, 0);
    check("arst_pix", pixel_count, 0);
    check("arst_clip", clip_count, 0);
    check("arst_done", done, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_ready", in_ready, 0);
    check("post_rst_rvalid", row_valid, 0);
    check("post_rst_done", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rect_pixel_collector.md
Name: rect_pixel_collector

Overview:
- Receiving end of the coordinate stream emitted by the generator-style drawing modules (for example draw_rectangle), which produce (_out0, _out1) beats and finish with _done.
- Accepts (row, column) beats over a valid/ready handshake and rasterises them into an on-chip bit-packed framebuffer.
- Keeps pixel, overlap and clip statistics, then streams the framebuffer out row by row.
- Used as the scoreboard and sink that sits behind drawing generators.

Parameters:
WIDTH, 32, coordinate and counter width
FB_W, 16, framebuffer columns (bits per row)
FB_H, 16, framebuffer rows

Ports:
_clock  input  1  rising-edge clock
_reset_n  input  1  asynchronous active-low reset
_start  input  1  synchronous one-cycle pulse: clear framebuffer and begin collecting
_in0  input  WIDTH  row coordinate (unsigned)
_in1  input  WIDTH  column coordinate (unsigned)
_in_valid  input  1  beat valid
_in_ready  output  1  collector can accept a beat
_in_done  input  1  producer finished (connects to the generator's _done)
_row_data  output  FB_W  framebuffer row contents; bit c = column c
_row_idx  output  WIDTH  index of the row on _row_data
_row_valid  output  1  readout beat valid
_row_ready  input  1  downstream accepts the readout beat
_pixel_count  output  WIDTH  in-bounds beats accepted
_overlap_count  output  WIDTH  in-bounds beats that hit an already-set bit
_clip_count  output  WIDTH  out-of-bounds beats accepted
_bb_min0, _bb_min1, _bb_max0, _bb_max1  output  WIDTH each  bounding box of in-bounds beats
_done  output  1  readout complete

Behaviour:
- Clock and reset: one clock, _clock. Reset _reset_n is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - _in_ready, _row_valid, _done, all counts, _row_idx, _bb_max0 and _bb_max1 are 0.
  - _bb_min0 and _bb_min1 are all ones.
  - _row_data is 0.
  - Framebuffer contents are undefined until a CLEAR pass completes.
- States: IDLE, CLEAR, COLLECT, READOUT, DONE.
- _start has priority in every state:
  - Next state is CLEAR.
  - Counts reset to 0 and the bounding box resets to its reset values.
  - _done, _in_ready and _row_valid go to 0.
  - This also applies when _start arrives mid-COLLECT or mid-READOUT.
- CLEAR:
  - Zeroes one row per cycle, rows 0..FB_H-1, which takes FB_H cycles.
  - Moves to COLLECT on the cycle after row FB_H-1 is cleared.
  - _in_ready stays 0 throughout.
- COLLECT:
  - _in_ready is 1.
  - A beat is accepted on a cycle where _in_valid and _in_ready are both 1.
  - In-bounds beat (_in0 < FB_H and _in1 < FB_W, unsigned compare):
    - fb[_in0][_in1] is set to 1.
    - _pixel_count increments.
    - If the bit was already 1, _overlap_count also increments.
    - The bounding box updates with min/max of each coordinate.
  - Out-of-bounds beat: only _clip_count increments; the framebuffer is untouched.
  - A beat on a cycle immediately following a beat to the same coordinate must still detect the overlap (read-after-write correct).
- _in_done in COLLECT:
  - Next state is READOUT and _in_ready drops.
  - If _in_valid is also 1 in that cycle, the beat is accepted first.
- READOUT:
  - _row_valid is 1, _row_idx = r, _row_data = fb[r], starting at r = 0.
  - r advances on each cycle where _row_valid and _row_ready are both 1.
  - Outputs hold stable while _row_ready is 0.
  - After the handshake on row FB_H-1, next state is DONE and _row_valid drops.
- DONE:
  - _done is 1 and held until _start or reset.
  - Counts, bounding box and framebuffer are retained.
- Counters wrap modulo 2^WIDTH.
- With no in-bounds beats, the bounding box stays at its reset values (min is all ones, max is 0), which signals an empty box.
- _in_valid outside COLLECT is ignored and nothing is accepted.
- Reset asserted mid-operation returns every output to its reset value immediately, with no clock edge needed.

Optional Feature:
- Macro: RECT_PIXEL_COLLECTOR_BBOX_EN
- Defined: bounding-box registers and update logic are present as described above.
- Undefined:
  - The four _bb_* ports still exist and are tied to 0.
  - No bounding-box registers are instantiated.
  - All other behaviour is unchanged.

Test Plan:
- Rectangle beats (feed the stream a rectangle generator emits: edges drawn with row 2 and row 5 over columns 3..7, then rows 2..5 at column 3 and column 7, as with s_x=2, s_y=3, height=4, width=5), then _in_done:
  -> _pixel_count=18, _overlap_count=4, _clip_count=0.
  -> Readout rows 2 and 5 = 0x00F8, rows 3 and 4 = 0x0088, all other rows 0x0000.
  -> Bounding box min (2,3), max (5,7); _done=1 after 16 readout handshakes.
- Beats (20,1) and (1,16) with FB 16x16 -> _clip_count=2, _pixel_count=0, all rows 0, bounding box min all ones and max 0.
- _in_valid=1 with beat (0,0) in the same cycle as _in_done -> beat accepted, row 0 = 0x0001, _in_ready low on the next cycle.
- Readout with _row_ready held low 3 cycles at row 4 -> _row_idx=4 and _row_data stable for those cycles; advances to 5 one cycle after _row_ready rises.
- _start pulse during READOUT at row 7 -> CLEAR for 16 cycles, counts 0, _done 0; a new collection shows no bits from the previous frame.
- _reset_n driven low asynchronously mid-COLLECT -> _in_ready, counts and _done at 0 before the next clock edge; state IDLE after release.
